// File: rtl/riscv_pkg.sv
// Shared core types for the fetch stage: fetch sequencer states and the canonical NOP.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;   // addi x0, x0, 0

   typedef enum logic [2:0] {
      REQ   = 3'd0,
      WAIT  = 3'd1,
      HOLD  = 3'd2,
      DROP  = 3'd3,
      FAULT = 3'd4
   } fetch_state_t;

   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bundle: single outstanding request, in-order response.
interface fetch_ctrl_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, addr, input gnt, rvalid, rdata);
   modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_buf.sv
// One-entry instruction word buffer used while decode is stalled; clear beats load.
module fetch_buf
   import riscv_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        clear_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        valid_o
);

   logic [31:0] data_q;
   logic        valid_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q  <= NOP_INSTRUCTION;
         valid_q <= 1'b0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
      end else if (load_i) begin
         data_q  <= data_i;
         valid_q <= 1'b1;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC register, imem handshake FSM, stale-response discard.
// Optional FETCH_MISALIGN_EN: misaligned redirect targets raise a fetch fault instead of being aligned.
module fetch_ctrl
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk_i,
   input  logic         rst_i,
   fetch_ctrl_if.master imem,
   input  logic         redirect_i,
   input  logic [31:0]  redirect_pc_i,
   input  logic         trap_i,
   input  logic [31:0]  trap_pc_i,
   input  logic         id_stall_i,
   output logic         if_d_valid,
   output logic         imem_rdata_valid,
   output logic [31:0]  if_d_pc,
   output logic [31:0]  if_d_pc_plus_4,
   output logic [31:0]  if_d_insn,
   output logic         if_id_stall,
   output logic         if_id_flush
`ifdef FETCH_MISALIGN_EN
   ,
   output logic         if_d_fetch_fault
`endif
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         fault_pend_q, fault_pend_d;

   logic         flush;
   logic [31:0]  raw_target;
   logic [31:0]  target;
   logic         target_bad;
   logic         buf_load, buf_clear, buf_valid;
   logic [31:0]  buf_data;
   logic         req_int, valid_int;
   logic [31:0]  insn_int;
`ifdef FETCH_MISALIGN_EN
   logic         fault_int;
`endif

   assign flush      = trap_i | redirect_i;
   assign raw_target = trap_i ? trap_pc_i : redirect_pc_i;

`ifdef FETCH_MISALIGN_EN
   assign target     = raw_target;
   assign target_bad = |raw_target[1:0];
`else
   assign target     = raw_target & 32'hFFFF_FFFC;
   assign target_bad = 1'b0;
`endif

   fetch_buf u_buf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (buf_load),
      .clear_i (buf_clear),
      .data_i  (imem.rdata),
      .data_o  (buf_data),
      .valid_o (buf_valid)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= REQ;
         pc_q         <= RESET_PC;
         fault_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fault_pend_q <= fault_pend_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fault_pend_d = fault_pend_q;
      buf_load     = 1'b0;
      buf_clear    = 1'b0;
      req_int      = 1'b0;
      valid_int    = 1'b0;
      insn_int     = NOP_INSTRUCTION;
`ifdef FETCH_MISALIGN_EN
      fault_int    = 1'b0;
`endif

      // fault_pend_q remembers whether the target behind a DROP must fault once the stale word lands
      if (flush) begin
         pc_d         = target;
         fault_pend_d = target_bad;
      end

      case (state_q)
         REQ: begin
            req_int = 1'b1;
            if (flush)
               state_d = imem.gnt ? DROP : (target_bad ? FAULT : REQ);
            else if (imem.gnt)
               state_d = WAIT;
         end
         WAIT: begin
            if (flush) begin
               state_d = imem.rvalid ? (target_bad ? FAULT : REQ) : DROP;
            end else if (imem.rvalid) begin
               valid_int = 1'b1;
               insn_int  = imem.rdata;
               if (!id_stall_i) begin
                  pc_d    = pc_inc(pc_q);
                  state_d = REQ;
               end else begin
                  buf_load = 1'b1;
                  state_d  = HOLD;
               end
            end
         end
         HOLD: begin
            if (flush) begin
               buf_clear = 1'b1;
               state_d   = target_bad ? FAULT : REQ;
            end else begin
               valid_int = buf_valid;
               insn_int  = buf_data;
               if (!id_stall_i) begin
                  buf_clear = 1'b1;
                  pc_d      = pc_inc(pc_q);
                  state_d   = REQ;
               end
            end
         end
         DROP: begin
            if (imem.rvalid)
               state_d = fault_pend_d ? FAULT : REQ;
         end
         FAULT: begin
            // pc_q holds the faulting target; the presentation persists until the next redirect
            if (flush) begin
               state_d = target_bad ? FAULT : REQ;
            end else begin
               valid_int = 1'b1;
`ifdef FETCH_MISALIGN_EN
               fault_int = 1'b1;
`endif
            end
         end
         default: state_d = REQ;
      endcase
   end

   assign imem.req         = req_int & ~rst_i;
   assign imem.addr        = pc_q;
   assign if_d_valid       = valid_int & ~rst_i;
   assign imem_rdata_valid = if_d_valid;
   assign if_d_insn        = if_d_valid ? insn_int : NOP_INSTRUCTION;
   assign if_d_pc          = pc_q;
   assign if_d_pc_plus_4   = pc_inc(pc_q);
   assign if_id_stall      = id_stall_i;
   assign if_id_flush      = flush;
`ifdef FETCH_MISALIGN_EN
   assign if_d_fetch_fault = fault_int & ~rst_i;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: imem responder, expected-PC-stream scoreboard, decoupled monitor.
module tb_fetch_ctrl;
   import riscv_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          NCYC   = 4000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_i = 1'b0, trap_i = 1'b0, id_stall_i = 1'b0;
   logic [31:0] redirect_pc_i = '0, trap_pc_i = '0;
   logic        if_d_valid, imem_rdata_valid, if_id_stall, if_id_flush;
   logic [31:0] if_d_pc, if_d_pc_plus_4, if_d_insn;
`ifdef FETCH_MISALIGN_EN
   logic        if_d_fetch_fault;
`endif

   always #5 clk = ~clk;

   fetch_ctrl_if imem ();

   fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .imem             (imem),
      .redirect_i       (redirect_i),
      .redirect_pc_i    (redirect_pc_i),
      .trap_i           (trap_i),
      .trap_pc_i        (trap_pc_i),
      .id_stall_i       (id_stall_i),
      .if_d_valid       (if_d_valid),
      .imem_rdata_valid (imem_rdata_valid),
      .if_d_pc          (if_d_pc),
      .if_d_pc_plus_4   (if_d_pc_plus_4),
      .if_d_insn        (if_d_insn),
      .if_id_stall      (if_id_stall),
      .if_id_flush      (if_id_flush)
`ifdef FETCH_MISALIGN_EN
      ,
      .if_d_fetch_fault (if_d_fetch_fault)
`endif
   );

   // Memory contents are a fixed function of the address, so any word can be predicted.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   int errors = 0, checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] next_push;
   logic        fault_exp = 1'b0;
   logic [31:0] fault_pc = '0;
   logic        pend = 1'b0, pend_start = 1'b0;
   logic [31:0] pend_addr = '0;
   int          lat = 0;
   int          consumed = 0, wrap_seen = 0, both_seen = 0, fault_seen = 0;
   logic        holding = 1'b0, prev_rst = 1'b1;
   int          idle_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic top_up();
      while (exp_q.size() < 8 && !fault_exp) begin
         exp_q.push_back(next_push);
         next_push = next_push + 32'd4;
      end
   endtask

   task automatic restart_stream(input logic [31:0] t);
      exp_q.delete();
      fault_exp = 1'b0;
      next_push = t;
      top_up();
   endtask

   function automatic logic [31:0] pick_target();
      logic [31:0] t;
      case ($urandom_range(0, 4))
         0:       t = 32'h0000_0200;
         1:       t = 32'h0000_0080;
         2:       t = 32'hFFFF_FFF8;
         3:       t = $urandom & 32'hFFFF_FFFC;
         default: t = ($urandom_range(0, 1) == 0) ? 32'h0000_0202 : $urandom;
      endcase
      return t;
   endfunction

   // Stimulus: imem responder, stall/redirect/trap generation, expected stream updates.
   initial begin
      logic        rv, g, st, rd_e, tr_e;
      logic [31:0] rdat, rpc, tpc, eff;
      restart_stream(RST_PC);
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         pend_start = pend;
         if (cyc < 3 || (cyc >= 2000 && cyc < 2003)) begin
            rst = 1'b1;
            imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
            redirect_i = 1'b0; trap_i = 1'b0; id_stall_i = 1'b0;
            pend = 1'b0;
            restart_stream(RST_PC);
            continue;
         end
         rst  = 1'b0;
         rv   = 1'b0;
         rdat = $urandom;
         if (pend) begin
            if (lat == 0) begin
               rv   = 1'b1;
               rdat = mem_word(pend_addr);
               pend = 1'b0;
            end else begin
               lat--;
            end
         end else if ($urandom_range(0, 9) == 0) begin
            rv = 1'b1;   // spurious response while nothing is outstanding
         end
         g = imem.req && ($urandom_range(0, 3) != 0);
         if (g) begin
            pend      = 1'b1;
            pend_addr = imem.addr;
            lat       = $urandom_range(0, 2);
         end
         st   = ($urandom_range(0, 9) < 4);
         rd_e = ($urandom_range(0, 99) < 3);
         tr_e = ($urandom_range(0, 99) < 2);
         rpc  = pick_target();
         tpc  = pick_target();
         if (rd_e || tr_e) begin
            eff = tr_e ? tpc : rpc;
            if (rd_e && tr_e) both_seen++;
`ifdef FETCH_MISALIGN_EN
            if (eff[1:0] != 2'b00) begin
               exp_q.delete();
               fault_exp = 1'b1;
               fault_pc  = eff;
            end else begin
               restart_stream(eff);
            end
`else
            restart_stream(eff & 32'hFFFF_FFFC);
`endif
         end else begin
            top_up();
         end
         imem.gnt = g; imem.rvalid = rv; imem.rdata = rdat;
         redirect_i = rd_e; redirect_pc_i = rpc;
         trap_i = tr_e; trap_pc_i = tpc;
         id_stall_i = st;
      end
      @(negedge clk);
      #3;
      chk("consumed_count_over_100", 32'(consumed > 100), 32'd1);
      chk("wrap_observed", 32'(wrap_seen > 0), 32'd1);
      chk("trap_and_redirect_observed", 32'(both_seen > 0), 32'd1);
`ifdef FETCH_MISALIGN_EN
      chk("fault_observed", 32'(fault_seen > 0), 32'd1);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Monitor: compares presented instructions against the head of the expected stream.
   always @(negedge clk) begin
      logic [31:0] head;
      #2;
      if (rst) begin
         chk("rst_req", 32'(imem.req), 32'd0);
         chk("rst_valid", 32'(if_d_valid), 32'd0);
         chk("rst_insn", if_d_insn, NOP_INSTRUCTION);
         chk("rst_flush", 32'(if_id_flush), 32'(trap_i | redirect_i));
         holding  = 1'b0;
         idle_cnt = 0;
      end else begin
         if (prev_rst) begin
            chk("first_req", 32'(imem.req), 32'd1);
            chk("first_addr", imem.addr, RST_PC);
         end
         chk("flush_out", 32'(if_id_flush), 32'(trap_i | redirect_i));
         chk("stall_out", 32'(if_id_stall), 32'(id_stall_i));
         chk("rdata_valid_eq", 32'(imem_rdata_valid), 32'(if_d_valid));
         chk("req_while_busy", 32'(imem.req && (pend_start || holding)), 32'd0);
         idle_cnt++;
         if (trap_i || redirect_i) begin
            chk("valid_on_flush", 32'(if_d_valid), 32'd0);
            holding = 1'b0;
`ifdef FETCH_MISALIGN_EN
         end else if (fault_exp) begin
            idle_cnt = 0;
            holding  = 1'b0;
            chk("fault_req", 32'(imem.req), 32'd0);
            if (if_d_valid) begin
               fault_seen++;
               chk("fault_flag", 32'(if_d_fetch_fault), 32'd1);
               chk("fault_pc", if_d_pc, fault_pc);
               chk("fault_insn", if_d_insn, NOP_INSTRUCTION);
            end
`endif
         end else if (if_d_valid) begin
            if (exp_q.size() == 0) begin
               chk("stream_underflow", 32'd1, 32'd0);
            end else begin
               head = exp_q[0];
               chk("pc", if_d_pc, head);
               chk("pc_plus_4", if_d_pc_plus_4, head + 32'd4);
               chk("insn", if_d_insn, mem_word(head));
`ifdef FETCH_MISALIGN_EN
               chk("no_fault", 32'(if_d_fetch_fault), 32'd0);
`endif
               if (!id_stall_i) begin
                  void'(exp_q.pop_front());
                  consumed++;
                  if (head == 32'hFFFF_FFFC) wrap_seen++;
                  holding  = 1'b0;
                  idle_cnt = 0;
               end else begin
                  holding = 1'b1;
               end
            end
         end else begin
            chk("insn_nop_when_invalid", if_d_insn, NOP_INSTRUCTION);
         end
         if (idle_cnt > 300) begin
            chk("progress_watchdog", 32'(idle_cnt), 32'd0);
            idle_cnt = 0;
         end
      end
      prev_rst = rst;
   end

endmodule
